// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl shared types and constants
// state encoding, digit codes, field limits
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    SET_HOUR,
    SET_MIN,
    SET_SEC
  } state_t;

  localparam logic [3:0] DASH  = 4'hA;
  localparam logic [3:0] BLANK = 4'hB;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  function automatic logic [5:0] wrap_step(
    input logic [5:0] v,
    input logic [5:0] mx,
    input logic       up
  );
    if (up) return (v >= mx) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? mx : v - 6'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_bin2bcd.sv
// clock_set_ctrl binary to BCD
// 0..59 split into tens and ones nibbles
module bin2bcd (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] sub;

  // range compare picks the tens digit
  always_comb begin
    tens = 4'd0;
    sub  = 6'd0;
    unique case (1'b1)
      (bin >= 6'd50): begin tens = 4'd5; sub = 6'd50; end
      (bin >= 6'd40 && bin < 6'd50): begin tens = 4'd4; sub = 6'd40; end
      (bin >= 6'd30 && bin < 6'd40): begin tens = 4'd3; sub = 6'd30; end
      (bin >= 6'd20 && bin < 6'd30): begin tens = 4'd2; sub = 6'd20; end
      (bin >= 6'd10 && bin < 6'd20): begin tens = 4'd1; sub = 6'd10; end
      default: begin tens = 4'd0; sub = 6'd0; end
    endcase
    ones = 4'(bin - sub);
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl time-set controller
// mode/up/down editing, timeout, digit mux
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic [3:0] dig6,
  output logic [3:0] dig7,
  output logic [7:0] point,
  output logic       is_shine,
  output logic [7:0] which_shine,
  output logic       set_load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_S - 1);

  state_t state, nxt;
  logic [4:0] edit_hour, eh_n;
  logic [5:0] edit_min, em_n;
  logic [5:0] edit_sec, es_n;
  logic [TW-1:0] tmo, tmo_n;
  logic load_n;
  logic any_btn;
  logic step;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= NORMAL;
    else          state <= nxt;
  end

  // next state, edit fields, timeout and commit
  always_comb begin
    nxt     = state;
    eh_n    = edit_hour;
    em_n    = edit_min;
    es_n    = edit_sec;
    tmo_n   = tmo;
    load_n  = 1'b0;
    any_btn = btn_mode | btn_up | btn_down;
    step    = btn_up ^ btn_down;
    unique case (state)
      NORMAL: begin
        if (btn_mode) begin
          nxt   = SET_HOUR;
          eh_n  = cur_hour;
          em_n  = cur_min;
          es_n  = cur_sec;
          tmo_n = '0;
        end
      end
      default: begin
        if (btn_mode) begin
          tmo_n = '0;
          unique case (state)
            SET_HOUR: nxt = SET_MIN;
            SET_MIN:  nxt = SET_SEC;
            default: begin
              nxt    = NORMAL;
              load_n = 1'b1;
            end
          endcase
        end else if (any_btn) begin
          tmo_n = '0;
          if (step) begin
            unique case (state)
              SET_HOUR: eh_n = 5'(wrap_step(
                {1'b0, edit_hour},
                {1'b0, HOUR_MAX}, btn_up));
              SET_MIN: em_n = wrap_step(
                edit_min, MINSEC_MAX, btn_up);
              default: es_n = wrap_step(
                edit_sec, MINSEC_MAX, btn_up);
            endcase
          end
        end else if (tick_1hz) begin
          if (tmo == LAST) begin
            nxt   = NORMAL;
            tmo_n = '0;
          end else begin
            tmo_n = tmo + 1'b1;
          end
        end
      end
    endcase
  end

  // edit registers, timeout counter, commit outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edit_hour <= '0;
      edit_min  <= '0;
      edit_sec  <= '0;
      tmo       <= '0;
      set_load  <= 1'b0;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
    end else begin
      edit_hour <= eh_n;
      edit_min  <= em_n;
      edit_sec  <= es_n;
      tmo       <= tmo_n;
      set_load  <= load_n;
      if (load_n) begin
        set_hour <= edit_hour;
        set_min  <= edit_min;
        set_sec  <= edit_sec;
      end
    end
  end

  logic       live;
  logic [5:0] src_hour, src_min, src_sec;

  assign live     = (state == NORMAL);
  assign src_hour = live ? {1'b0, cur_hour} : {1'b0, edit_hour};
  assign src_min  = live ? cur_min : edit_min;
  assign src_sec  = live ? cur_sec : edit_sec;

  bin2bcd u_hour (.bin(src_hour), .tens(dig7), .ones(dig6));
  bin2bcd u_min  (.bin(src_min),  .tens(dig4), .ones(dig3));
  bin2bcd u_sec  (.bin(src_sec),  .tens(dig1), .ones(dig0));

  assign dig5  = DASH;
  assign dig2  = DASH;
  assign point = 8'hFF;

  // blink control follows the field being edited
  always_comb begin
    is_shine    = 1'b1;
    which_shine = 8'h00;
    unique case (state)
      SET_HOUR: which_shine = 8'hC0;
      SET_MIN:  which_shine = 8'h18;
      SET_SEC:  which_shine = 8'h03;
      default:  is_shine = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// clock_set_ctrl directed testbench
// hand-computed vectors
module tb_clock_set_ctrl;

  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic tick_1hz, btn_mode, btn_up, btn_down;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [3:0] dig4, dig5, dig6, dig7;
  logic [7:0] point, which_shine;
  logic is_shine, set_load;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;

  int n_chk = 0;
  int n_err = 0;
  int loads = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .cur_sec(cur_sec),
    .dig0(dig0), .dig1(dig1), .dig2(dig2),
    .dig3(dig3), .dig4(dig4), .dig5(dig5),
    .dig6(dig6), .dig7(dig7),
    .point(point), .is_shine(is_shine),
    .which_shine(which_shine),
    .set_load(set_load), .set_hour(set_hour),
    .set_min(set_min), .set_sec(set_sec)
  );

  wire [31:0] digs = {dig7, dig6, dig5, dig4,
                      dig3, dig2, dig1, dig0};

  always @(negedge clk) if (set_load) loads++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic pulse(input logic m, input logic u,
                       input logic d, input logic t);
    btn_mode = m; btn_up = u;
    btn_down = d; tick_1hz = t;
    @(posedge clk); #1;
    btn_mode = 0; btn_up = 0;
    btn_down = 0; tick_1hz = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle(2);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; tick_1hz = 0;
    btn_mode = 0; btn_up = 0; btn_down = 0;
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;

    // reset state and live display
    do_reset();
    chk("rst_digs", digs, 32'h12A34A56);
    chk("rst_shine", is_shine, 0);
    chk("rst_which", which_shine, 8'h00);
    chk("rst_load", set_load, 0);
    chk("rst_point", point, 8'hFF);
    chk("rst_sethr", set_hour, 0);

    // up past 23 wraps to 0, down wraps back
    pulse(1, 0, 0, 0);
    chk("sh_which", which_shine, 8'hC0);
    chk("sh_shine", is_shine, 1);
    cur_hour = 5'd5;
    #1 chk("sh_copy", digs, 32'h12A34A56);
    for (int i = 0; i < 12; i++) pulse(0, 1, 0, 0);
    chk("hr_wrap_up", digs, 32'h00A34A56);
    pulse(0, 0, 1, 0);
    chk("hr_wrap_dn", digs, 32'h23A34A56);
    do_reset();

    // minute wrap down and commit
    cur_hour = 5'd12; cur_min = 6'd0; cur_sec = 6'd30;
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("sm_which", which_shine, 8'h18);
    pulse(0, 0, 1, 0);
    chk("min_wrap", digs, 32'h12A59A30);
    pulse(1, 0, 0, 0);
    chk("ss_which", which_shine, 8'h03);
    chk("ss_noload", set_load, 0);
    pulse(1, 0, 0, 0);
    chk("cm_load", set_load, 1);
    chk("cm_min", set_min, 59);
    chk("cm_hour", set_hour, 12);
    chk("cm_sec", set_sec, 30);
    chk("cm_which", which_shine, 8'h00);
    chk("cm_live", digs, 32'h12A00A30);
    idle(1);
    chk("cm_pulse1", set_load, 0);
    chk("cm_hold", set_min, 59);

    // timeout, with a press restarting the count
    loads = 0;
    pulse(1, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) pulse(0, 0, 0, 1);
    chk("to_early", which_shine, 8'hC0);
    pulse(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) pulse(0, 0, 0, 1);
    chk("to_clear", which_shine, 8'hC0);
    chk("to_edit", digs, 32'h13A00A30);
    pulse(0, 0, 0, 1);
    chk("to_exit", which_shine, 8'h00);
    chk("to_shine", is_shine, 0);
    idle(2);
    chk("to_noload", loads, 0);
    chk("to_keep", set_hour, 12);

    // second wraps 59 -> 0
    cur_sec = 6'd59;
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("sec_wrap", digs, 32'h12A00A00);
    pulse(1, 0, 0, 0);
    chk("sw_sec", set_sec, 0);

    // up+down ignored, mode beats up
    cur_sec = 6'd30;
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 1, 0);
    chk("updn_sec", digs, 32'h12A00A30);
    pulse(1, 1, 0, 0);
    chk("mu_load", set_load, 1);
    chk("mu_sec", set_sec, 30);
    chk("mu_which", which_shine, 8'h00);

    // reset in SET_MIN discards edit
    idle(1);
    loads = 0;
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    reset_n = 0;
    pulse(0, 0, 0, 0);
    reset_n = 1;
    chk("rm_which", which_shine, 8'h00);
    chk("rm_load", set_load, 0);
    chk("rm_min", set_min, 0);
    idle(3);
    chk("rm_noload", loads, 0);
    chk("rm_live", digs, 32'h12A00A30);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
